// File: rtl/npc_predict_if.sv
// Fetch/execute bus of the next-PC predictor.
//   master: pipeline side. It drives fetch_pc and the res_* resolve fields,
//           and it receives the prediction and redirect results.
//   slave : npc_predict. It receives lookups and resolves, and it returns
//           pred_pc, pred_taken, pred_hit, redirect and redirect_pc.
interface npc_predict_if;
    logic [31:0] fetch_pc;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        pred_hit;
    logic        res_valid;
    logic [1:0]  res_kind;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output fetch_pc, res_valid, res_kind, res_pc, res_taken, res_target,
               res_pred_taken, res_pred_target,
        input  pred_pc, pred_taken, pred_hit, redirect, redirect_pc
    );

    modport slave (
        input  fetch_pc, res_valid, res_kind, res_pc, res_taken, res_target,
               res_pred_taken, res_pred_target,
        output pred_pc, pred_taken, pred_hit, redirect, redirect_pc
    );
endinterface

// File: rtl/npc_predict.sv
// Next-PC unit with a direct-mapped BTB and 2-bit saturating counters.
// The fetch lookup and the execute resolve/redirect are both combinational.
// BTB updates and the statistics counters are registered.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   bus (slave)     fetch lookup, resolve inputs, prediction and redirect
//   stat_clear      synchronous clear of the statistics counters
//   uncond_cnt      saturating count of kind 10/11 resolves
//   cond_cnt        saturating count of kind 01 resolves
//   cond_taken_cnt  saturating count of taken kind 01 resolves
//   mispred_cnt     saturating count of redirects
module npc_predict #(
    parameter int unsigned ENTRIES    = 16,
    parameter int unsigned CNT_W      = 16,
    parameter logic [1:0]  INIT_CTR   = 2'b01,
    parameter bit          JR_PREDICT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    npc_predict_if.slave     bus,
    input  logic             stat_clear,
    output logic [CNT_W-1:0] uncond_cnt,
    output logic [CNT_W-1:0] cond_cnt,
    output logic [CNT_W-1:0] cond_taken_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic             uncond_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] f_idx, r_idx;
    logic [TAG_W-1:0] f_tag, r_tag;
    logic             r_hit;
    logic             act_taken;
    logic [31:0]      act_pc;
    logic             mispredict;

    logic             wr_en;
    logic             wr_valid;
    logic             wr_uncond;
    logic [1:0]       wr_ctr;
    logic [31:0]      wr_target;

    assign f_idx = bus.fetch_pc[IDX_W+1:2];
    assign f_tag = bus.fetch_pc[31:IDX_W+2];
    assign r_idx = bus.res_pc[IDX_W+1:2];
    assign r_tag = bus.res_pc[31:IDX_W+2];

    // Fetch lookup; sees pre-update contents when the same index is written this cycle
    always_comb begin
        bus.pred_hit   = rst_n && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        bus.pred_taken = bus.pred_hit && (uncond_q[f_idx] || ctr_q[f_idx][1]);
        bus.pred_pc    = bus.pred_taken ? target_q[f_idx] : bus.fetch_pc + 32'd4;
    end

    // Resolve: actual outcome versus the prediction that travelled with the instruction
    always_comb begin
        unique case (bus.res_kind)
            2'b00:   act_taken = 1'b0;
            2'b01:   act_taken = bus.res_taken;
            default: act_taken = 1'b1;
        endcase
        act_pc     = act_taken ? bus.res_target : bus.res_pc + 32'd4;
        mispredict = (bus.res_pred_taken != act_taken) ||
                     (act_taken && (bus.res_pred_target != bus.res_target));
        bus.redirect    = rst_n && bus.res_valid && mispredict;
        bus.redirect_pc = act_pc;
    end

    assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

    // BTB write decision for the resolving instruction's slot
    always_comb begin
        wr_en     = 1'b0;
        wr_valid  = valid_q[r_idx];
        wr_uncond = uncond_q[r_idx];
        wr_ctr    = ctr_q[r_idx];
        wr_target = target_q[r_idx];
        if (bus.res_valid) begin
            unique case (bus.res_kind)
                2'b01: begin
                    if (r_hit) begin
                        wr_en = 1'b1;
                        if (bus.res_taken) begin
                            wr_target = bus.res_target;
                            if (wr_ctr != 2'b11) wr_ctr = wr_ctr + 2'd1;
                        end else if (wr_ctr != 2'b00) begin
                            wr_ctr = wr_ctr - 2'd1;
                        end
                    end else if (bus.res_taken) begin
                        wr_en     = 1'b1;
                        wr_valid  = 1'b1;
                        wr_uncond = 1'b0;
                        wr_ctr    = 2'b10;
                        wr_target = bus.res_target;
                    end
                end
                2'b10, 2'b11: begin
                    if (bus.res_kind == 2'b10 || JR_PREDICT) begin
                        wr_en     = 1'b1;
                        wr_valid  = 1'b1;
                        wr_uncond = 1'b1;
                        wr_ctr    = 2'b11;
                        wr_target = bus.res_target;
                    end
                end
                default: begin
                    // A non-branch that hits has aliased onto a stale entry
                    if (r_hit) begin
                        wr_en    = 1'b1;
                        wr_valid = 1'b0;
                    end
                end
            endcase
        end
    end

    // BTB storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[IDX_W'(i)]  <= 1'b0;
                tag_q[IDX_W'(i)]    <= '0;
                target_q[IDX_W'(i)] <= '0;
                uncond_q[IDX_W'(i)] <= 1'b0;
                ctr_q[IDX_W'(i)]    <= INIT_CTR;
            end
        end else if (wr_en) begin
            valid_q[r_idx]  <= wr_valid;
            tag_q[r_idx]    <= r_tag;
            target_q[r_idx] <= wr_target;
            uncond_q[r_idx] <= wr_uncond;
            ctr_q[r_idx]    <= wr_ctr;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Statistics; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uncond_cnt     <= '0;
            cond_cnt       <= '0;
            cond_taken_cnt <= '0;
            mispred_cnt    <= '0;
        end else if (stat_clear) begin
            uncond_cnt     <= '0;
            cond_cnt       <= '0;
            cond_taken_cnt <= '0;
            mispred_cnt    <= '0;
        end else if (bus.res_valid) begin
            if (bus.res_kind[1]) uncond_cnt <= sat_inc(uncond_cnt);
            if (bus.res_kind == 2'b01) begin
                cond_cnt <= sat_inc(cond_cnt);
                if (bus.res_taken) cond_taken_cnt <= sat_inc(cond_taken_cnt);
            end
            if (bus.redirect) mispred_cnt <= sat_inc(mispred_cnt);
        end
    end
endmodule

// File: tb/tb_npc_predict.sv
// Bench for npc_predict with ENTRIES=16, CNT_W=4 and JR_PREDICT=1.
// It runs directed scenarios first and then random traffic. A table-level
// model of the BTB is checked against the DUT on every falling edge.
module tb_npc_predict;
    localparam int NENT = 16;
    localparam int CMAX = 15;

    logic       clk;
    logic       rst_n;
    logic       stat_clear;
    logic [3:0] uncond_cnt, cond_cnt, cond_taken_cnt, mispred_cnt;

    npc_predict_if bus();

    npc_predict #(.ENTRIES(16), .CNT_W(4), .INIT_CTR(2'b01), .JR_PREDICT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .stat_clear(stat_clear),
        .uncond_cnt(uncond_cnt), .cond_cnt(cond_cnt),
        .cond_taken_cnt(cond_taken_cnt), .mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit        v;
        bit [31:0] tag;
        bit [31:0] tgt;
        bit        unc;
        int        ctr;
    } ment_t;

    ment_t m [NENT];
    int m_unc, m_cond, m_ctk, m_mis;

    function automatic void m_reset();
        for (int i = 0; i < NENT; i++) m[i] = '{0, 0, 0, 0, 1};
        m_unc = 0; m_cond = 0; m_ctk = 0; m_mis = 0;
    endfunction

    function automatic int idx_of(input bit [31:0] pc);
        return int'((pc >> 2) % NENT);
    endfunction

    function automatic void m_lookup(input bit [31:0] pc, output bit hit,
                                     output bit tk, output bit [31:0] npc);
        int i;
        i   = idx_of(pc);
        hit = m[i].v && (m[i].tag == (pc >> 6));
        tk  = hit && (m[i].unc || m[i].ctr >= 2);
        npc = tk ? m[i].tgt : pc + 32'd4;
    endfunction

    function automatic void m_resolve(output bit mis, output bit [31:0] rpc);
        bit at;
        at  = (bus.res_kind == 2'b00) ? 1'b0 : (bus.res_kind == 2'b01) ? bus.res_taken : 1'b1;
        rpc = at ? bus.res_target : bus.res_pc + 32'd4;
        mis = (bus.res_pred_taken != at) || (at && bus.res_pred_target != bus.res_target);
    endfunction

    function automatic void m_update();
        bit mis, hit;
        bit [31:0] rpc, tag;
        int i;
        m_resolve(mis, rpc);
        i   = idx_of(bus.res_pc);
        tag = bus.res_pc >> 6;
        hit = m[i].v && m[i].tag == tag;
        if (bus.res_valid) begin
            case (bus.res_kind)
                2'b01: begin
                    if (hit) begin
                        if (bus.res_taken) begin
                            m[i].ctr = (m[i].ctr < 3) ? m[i].ctr + 1 : 3;
                            m[i].tgt = bus.res_target;
                        end else begin
                            m[i].ctr = (m[i].ctr > 0) ? m[i].ctr - 1 : 0;
                        end
                    end else if (bus.res_taken) begin
                        m[i] = '{1, tag, bus.res_target, 0, 2};
                    end
                end
                2'b10, 2'b11: m[i] = '{1, tag, bus.res_target, 1, 3};
                default: if (hit) m[i].v = 0;
            endcase
        end
        if (stat_clear) begin
            m_unc = 0; m_cond = 0; m_ctk = 0; m_mis = 0;
        end else if (bus.res_valid) begin
            if (bus.res_kind[1] && m_unc < CMAX) m_unc++;
            if (bus.res_kind == 2'b01 && m_cond < CMAX) m_cond++;
            if (bus.res_kind == 2'b01 && bus.res_taken && m_ctk < CMAX) m_ctk++;
            if (mis && m_mis < CMAX) m_mis++;
        end
    endfunction

    always @(negedge rst_n) m_reset();

    always @(posedge clk) if (rst_n === 1'b1) m_update();

    // Per-cycle compare against the model
    always @(negedge clk) begin
        bit hit, tk, mis;
        bit [31:0] npc, rpc;
        m_lookup(bus.fetch_pc, hit, tk, npc);
        m_resolve(mis, rpc);
        if (!rst_n) begin
            hit = 0; tk = 0; npc = bus.fetch_pc + 32'd4; mis = 0;
        end
        chk("pred_hit", 32'(bus.pred_hit), 32'(hit));
        chk("pred_taken", 32'(bus.pred_taken), 32'(tk));
        chk("pred_pc", bus.pred_pc, npc);
        chk("redirect", 32'(bus.redirect), 32'(mis && bus.res_valid));
        if (mis && bus.res_valid) chk("redirect_pc", bus.redirect_pc, rpc);
        chk("uncond_cnt", 32'(uncond_cnt), 32'(m_unc));
        chk("cond_cnt", 32'(cond_cnt), 32'(m_cond));
        chk("cond_taken_cnt", 32'(cond_taken_cnt), 32'(m_ctk));
        chk("mispred_cnt", 32'(mispred_cnt), 32'(m_mis));
    end

    // ---------------- stimulus helpers ----------------
    task automatic go();
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
        stat_clear    = 1'b0;
    endtask

    task automatic set_res(input bit [1:0] kind, input bit [31:0] pc, input bit tk,
                           input bit [31:0] tgt, input bit ptk, input bit [31:0] ptgt);
        bus.res_valid       = 1'b1;
        bus.res_kind        = kind;
        bus.res_pc          = pc;
        bus.res_taken       = tk;
        bus.res_target      = tgt;
        bus.res_pred_taken  = ptk;
        bus.res_pred_target = ptgt;
    endtask

    bit exp_tk  [5] = '{1, 1, 1, 0, 0};
    bit outcome [5] = '{1, 1, 0, 0, 0};

    initial begin
        bit hit, tk;
        bit [31:0] npc;
        m_reset();
        rst_n = 1'b0;
        stat_clear = 1'b0;
        bus.fetch_pc = 32'h0040_0000;
        bus.res_valid = 1'b0;
        bus.res_kind = 2'b00;
        bus.res_pc = 32'h0;
        bus.res_taken = 1'b0;
        bus.res_target = 32'h0;
        bus.res_pred_taken = 1'b0;
        bus.res_pred_target = 32'h0;
        go(); go();
        rst_n = 1'b1;
        #1;

        // Empty BTB after reset
        chk("rst_hit", 32'(bus.pred_hit), 32'd0);
        chk("rst_taken", 32'(bus.pred_taken), 32'd0);
        chk("rst_pc", bus.pred_pc, 32'h0040_0004);
        chk("rst_mis_cnt", 32'(mispred_cnt), 32'd0);

        // Direct jump: redirect, install, then predicted taken
        set_res(2'b10, 32'h0040_0010, 1'b0, 32'h0040_0100, 1'b0, 32'h0);
        #1;
        chk("j_redirect", 32'(bus.redirect), 32'd1);
        chk("j_redirect_pc", bus.redirect_pc, 32'h0040_0100);
        go(); #1;
        chk("j_mis_cnt", 32'(mispred_cnt), 32'd1);
        chk("j_unc_cnt", 32'(uncond_cnt), 32'd1);
        bus.fetch_pc = 32'h0040_0010;
        #1;
        chk("j_pred_pc", bus.pred_pc, 32'h0040_0100);
        chk("j_pred_taken", 32'(bus.pred_taken), 32'd1);

        // Conditional training T,T,N,N,N with the prediction carried along
        bus.fetch_pc = 32'h0040_0020;
        for (int i = 0; i < 5; i++) begin
            m_lookup(32'h0040_0020, hit, tk, npc);
            set_res(2'b01, 32'h0040_0020, outcome[i], 32'h0040_0080, tk, npc);
            go(); #1;
            chk($sformatf("cond_pred_taken%0d", i), 32'(bus.pred_taken), 32'(exp_tk[i]));
        end
        chk("cond_cnt5", 32'(cond_cnt), 32'd5);
        chk("cond_taken_cnt2", 32'(cond_taken_cnt), 32'd2);
        chk("cond_mis_cnt", 32'(mispred_cnt), 32'd4);

        // Aliasing: a different tag at the same index leaves the entry alone
        set_res(2'b10, 32'h0040_0000, 1'b0, 32'h0040_0200, 1'b0, 32'h0);
        go();
        bus.fetch_pc = 32'h0040_0000;
        #1;
        chk("alias_hit0", 32'(bus.pred_hit), 32'd1);
        set_res(2'b00, 32'h0040_0040, 1'b0, 32'h0, 1'b1, 32'h0040_0200);
        #1;
        chk("alias_redirect", 32'(bus.redirect), 32'd1);
        chk("alias_redirect_pc", bus.redirect_pc, 32'h0040_0044);
        go(); #1;
        chk("alias_hit1", 32'(bus.pred_hit), 32'd1);
        set_res(2'b00, 32'h0040_0000, 1'b0, 32'h0, 1'b1, 32'h0040_0200);
        go(); #1;
        chk("alias_inval", 32'(bus.pred_hit), 32'd0);
        chk("alias_mis_cnt", 32'(mispred_cnt), 32'd7);

        // Counter saturation, then clear beating an increment
        for (int i = 0; i < 17; i++) begin
            set_res(2'b00, 32'h0050_0000 + 32'(4 * i), 1'b0, 32'h0, 1'b1, 32'h0050_0100);
            go();
        end
        #1;
        chk("mis_sat", 32'(mispred_cnt), 32'd15);
        set_res(2'b00, 32'h0060_0000, 1'b0, 32'h0, 1'b1, 32'h0060_0100);
        stat_clear = 1'b1;
        go(); #1;
        chk("clr_mis", 32'(mispred_cnt), 32'd0);
        chk("clr_unc", 32'(uncond_cnt), 32'd0);
        chk("clr_cond", 32'(cond_cnt), 32'd0);

        // Asynchronous reset drops a live hit without a clock edge
        bus.fetch_pc = 32'h0040_0010;
        #1;
        chk("prerst_hit", 32'(bus.pred_hit), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_hit", 32'(bus.pred_hit), 32'd0);
        chk("async_pc", bus.pred_pc, 32'h0040_0014);
        go(); go();
        rst_n = 1'b1;
        #1;
        chk("postrst_hit", 32'(bus.pred_hit), 32'd0);

        // Random traffic over a small PC pool so entries alias and retrain
        for (int c = 0; c < 3000; c++) begin
            bit [31:0] rpc;
            bus.fetch_pc = 32'h0040_0000 + 32'(4 * $urandom_range(0, 47));
            rpc = 32'h0040_0000 + 32'(4 * $urandom_range(0, 47));
            m_lookup(rpc, hit, tk, npc);
            if ($urandom_range(0, 3) == 0) begin
                tk  = 1'($urandom);
                npc = 32'h0040_0000 + 32'(4 * $urandom_range(0, 255));
            end
            set_res(2'($urandom), rpc, 1'($urandom),
                    32'h0040_0000 + 32'(4 * $urandom_range(0, 255)), tk, npc);
            bus.res_valid = ($urandom_range(0, 4) != 0);
            stat_clear = ($urandom_range(0, 49) == 0);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            go();
        end
        rst_n = 1'b1;
        go(); go();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
